force_array_ctrl: RTL and testbench

Drives the per-element force/release controls for an N-element forceable signal array. It sits in front of the force-mux array, on the source side of the per-element `force`, `force_value` and `release` nets. Host commands arrive over a valid/ready port. Commands are applied immediately while `en` is high, or armed while `en` is low and applied in bulk on the rising edge of `en`. A falling edge of `en` triggers an ordered release sweep that returns every element to its driven value.

---
 rtl/force_array_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_force_array_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/force_array_ctrl.sv
// Per-element force/release controller for an N-element forceable signal array.
// Commands apply immediately while en is high, arm while en is low, and a falling en sweeps all releases.
module force_array_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 1,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IW-1:0]      cmd_idx,
  input  logic [W-1:0]       cmd_value,
  output logic [N-1:0]       force_o,
  output logic [N*W-1:0]     force_value_o,
  output logic [N-1:0]       release_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned IW1 = IW + 1;

  localparam logic [1:0] OP_NOP         = 2'd0;
  localparam logic [1:0] OP_FORCE       = 2'd1;
  localparam logic [1:0] OP_RELEASE     = 2'd2;
  localparam logic [1:0] OP_RELEASE_ALL = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               en_q;
  logic [N-1:0]       armed_q, armed_d;
  logic [N*W-1:0]     arm_val_q, arm_val_d;
  logic               apply_pend_q, apply_pend_d;
  logic [N-1:0]       force_q, force_d;
  logic [N*W-1:0]     fval_q, fval_d;
  logic [N-1:0]       rel_q, rel_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               rise_c;
  logic               fall_c;
  logic               cmd_fire_c;
  logic               idx_ok_c;
  logic               start_sweep;
  logic [N-1:0]       sel;

  // Isolate the lowest set bit; the sweep releases in ascending index order.
  function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  assign rise_c     = en & ~en_q;
  assign fall_c     = ~en & en_q;
  assign cmd_ready  = (state_q == ST_IDLE) & ~rise_c & ~fall_c & ~apply_pend_q;
  assign cmd_fire_c = cmd_valid & cmd_ready;
  assign idx_ok_c   = ({1'b0, cmd_idx} < IW1'(N));

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    arm_val_d    = arm_val_q;
    apply_pend_d = apply_pend_q;
    force_d      = force_q;
    fval_d       = fval_q;
    rel_d        = '0;
    err_d        = 1'b0;
    start_sweep  = 1'b0;
    sel          = '0;

    case (state_q)
      ST_IDLE: begin
        // Bulk apply of armed elements on a rise or on a rise deferred from the sweep.
        if (rise_c || apply_pend_q) begin
          force_d = force_q | armed_q;
          for (int unsigned i = 0; i < N; i++) begin
            if (armed_q[i]) fval_d[i*W +: W] = arm_val_q[i*W +: W];
          end
          armed_d      = '0;
          apply_pend_d = 1'b0;
        end

        if (fall_c) start_sweep = 1'b1;

        if (cmd_fire_c) begin
          case (cmd_op)
            OP_FORCE: begin
              if (!idx_ok_c) begin
                err_d = 1'b1;
              end else begin
                for (int unsigned i = 0; i < N; i++) begin
                  if (cmd_idx == IW'(i)) begin
                    if (en) begin
                      force_d[i]         = 1'b1;
                      fval_d[i*W +: W]   = cmd_value;
                    end else begin
                      armed_d[i]         = 1'b1;
                      arm_val_d[i*W +: W] = cmd_value;
                    end
                  end
                end
              end
            end
            OP_RELEASE: begin
              if (!idx_ok_c) begin
                err_d = 1'b1;
              end else begin
                for (int unsigned i = 0; i < N; i++) begin
                  if (cmd_idx == IW'(i)) begin
                    force_d[i] = 1'b0;
                    armed_d[i] = 1'b0;
                    rel_d[i]   = 1'b1;
                  end
                end
              end
            end
            OP_RELEASE_ALL: start_sweep = 1'b1;
            OP_NOP:         ;
            default:        ;
          endcase
        end

        // The first sweep release is issued on entry so pulses line up with the busy window.
        if (start_sweep) begin
          sel     = lowest_bit(force_d);
          rel_d   = sel;
          force_d = force_d & ~sel;
          state_d = ST_SWEEP;
        end
      end

      ST_SWEEP: begin
        if (rise_c) apply_pend_d = 1'b1;
        sel     = lowest_bit(force_q);
        rel_d   = sel;
        force_d = force_q & ~sel;
        // Leave only after one sweep cycle with nothing left to release.
        if (force_q == '0 && rel_q == '0) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SWEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      en_q         <= 1'b0;
      armed_q      <= '0;
      arm_val_q    <= '0;
      apply_pend_q <= 1'b0;
      force_q      <= '0;
      fval_q       <= '0;
      rel_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en;
      armed_q      <= armed_d;
      arm_val_q    <= arm_val_d;
      apply_pend_q <= apply_pend_d;
      force_q      <= force_d;
      fval_q       <= fval_d;
      rel_q        <= rel_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign force_o       = force_q;
  assign force_value_o = fval_q;
  assign release_o     = rel_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_force_array_ctrl.sv
// Self-checking bench for force_array_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a list-based behavioural model.
module tb_force_array_ctrl;

  localparam int unsigned N  = 10;
  localparam int unsigned W  = 2;
  localparam int unsigned IW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'd0;
  logic [IW-1:0]   cmd_idx = '0;
  logic [W-1:0]    cmd_value = '0;
  logic [N-1:0]    force_o;
  logic [N*W-1:0]  force_value_o;
  logic [N-1:0]    release_o;
  logic            busy_o;
  logic            err_o;

  force_array_ctrl #(.N(N), .W(W), .IW(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_idx       (cmd_idx),
    .cmd_value     (cmd_value),
    .force_o       (force_o),
    .force_value_o (force_value_o),
    .release_o     (release_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic obs_ready;

  // Reference model state
  bit m_force [N];
  int m_val   [N];
  bit m_armed [N];
  int m_aval  [N];
  bit m_pend, m_busy, m_err, m_prev_en;
  int m_rel;
  int sweep_list [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_force[i] = 0; m_val[i] = 0; m_armed[i] = 0; m_aval[i] = 0;
    end
    m_pend = 0; m_busy = 0; m_err = 0; m_prev_en = 0; m_rel = -1;
    sweep_list.delete();
  endtask

  function automatic logic [31:0] exp_force();
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_force[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_val();
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_val[i]);
    return r;
  endfunction

  function automatic logic [31:0] exp_rel();
    logic [31:0] r = '0;
    if (m_rel >= 0) r[m_rel] = 1'b1;
    return r;
  endfunction

  function automatic logic model_ready();
    logic rise, fall;
    rise = en && !m_prev_en;
    fall = !en && m_prev_en;
    return !m_busy && !rise && !fall && !m_pend;
  endfunction

  // One clock of the behavioural model, using the inputs sampled at this edge.
  task automatic model_step();
    bit rise, fall, rdy, acc, start, nerr, nbusy;
    int e, idx, nrel;
    rise  = en && !m_prev_en;
    fall  = !en && m_prev_en;
    rdy   = !m_busy && !rise && !fall && !m_pend;
    acc   = cmd_valid && rdy;
    idx   = int'(cmd_idx);
    nrel  = -1; nerr = 0; nbusy = 0; start = 0;
    if (m_busy) begin
      if (rise) m_pend = 1;
      if (sweep_list.size() > 0) begin
        e = sweep_list.pop_front();
        nbusy = 1;
        if (e >= 0) begin m_force[e] = 0; nrel = e; end
      end
    end else begin
      if (rise || m_pend) begin
        for (int i = 0; i < N; i++) begin
          if (m_armed[i]) begin m_force[i] = 1; m_val[i] = m_aval[i]; m_armed[i] = 0; end
        end
        m_pend = 0;
      end
      start = fall;
      if (acc) begin
        case (cmd_op)
          2'd1: begin
            if (idx >= N) nerr = 1;
            else if (en) begin m_force[idx] = 1; m_val[idx] = int'(cmd_value); end
            else begin m_armed[idx] = 1; m_aval[idx] = int'(cmd_value); end
          end
          2'd2: begin
            if (idx >= N) nerr = 1;
            else begin m_force[idx] = 0; m_armed[idx] = 0; nrel = idx; end
          end
          2'd3: start = 1;
          default: ;
        endcase
      end
      if (start) begin
        // Release list: forced elements ascending, then one empty closing cycle.
        sweep_list.delete();
        for (int i = 0; i < N; i++) if (m_force[i]) sweep_list.push_back(i);
        sweep_list.push_back(-1);
        e = sweep_list.pop_front();
        nbusy = 1;
        if (e >= 0) begin m_force[e] = 0; nrel = e; end
      end
    end
    m_busy = nbusy; m_rel = nrel; m_err = nerr; m_prev_en = en;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_force"}, 32'(force_o), exp_force());
    check_eq({tag, "_value"}, 32'(force_value_o), exp_val());
    check_eq({tag, "_release"}, 32'(release_o), exp_rel());
    check_eq({tag, "_busy"}, 32'(busy_o), 32'(m_busy));
    check_eq({tag, "_err"}, 32'(err_o), 32'(m_err));
  endtask

  // Drive one cycle of inputs, check cmd_ready, clock, then check registered outputs.
  task automatic step(input logic e, input logic v, input logic [1:0] op, input int idx, input int val);
    en = e; cmd_valid = v; cmd_op = op; cmd_idx = IW'(idx); cmd_value = W'(val);
    #1;
    obs_ready = cmd_ready;
    check_eq("ready", 32'(cmd_ready), 32'(model_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check_eq("rst_ready", 32'(cmd_ready), 32'(model_ready()));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check_eq("reset_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    // Arm while disabled, apply on rise
    step(0, 1, 2'd1, 3, 1);
    check_eq("arm_no_force", 32'(force_o), 32'h0);
    step(1, 0, 2'd0, 0, 0);
    check_eq("rise_force", 32'(force_o), 32'h008);
    check_eq("rise_val3", 32'(force_value_o[7:6]), 32'd1);

    // Immediate force and release
    step(1, 1, 2'd1, 0, 1);
    check_eq("imm_force", 32'(force_o), 32'h009);
    step(1, 1, 2'd2, 0, 0);
    check_eq("rel_pulse", 32'(release_o), 32'h001);
    check_eq("rel_force", 32'(force_o), 32'h008);
    step(1, 0, 2'd0, 0, 0);
    check_eq("rel_one_cycle", 32'(release_o), 32'h000);

    // Fall sweep over elements 1, 4, 6
    step(1, 1, 2'd2, 3, 0);
    step(1, 1, 2'd1, 1, 1);
    step(1, 1, 2'd1, 4, 2);
    step(1, 1, 2'd1, 6, 3);
    step(0, 0, 2'd0, 0, 0);
    check_eq("sweep_rel1", 32'(release_o), 32'h002);
    check_eq("sweep_busy1", 32'(busy_o), 32'd1);
    step(0, 0, 2'd0, 0, 0);
    check_eq("sweep_rel2", 32'(release_o), 32'h010);
    step(0, 0, 2'd0, 0, 0);
    check_eq("sweep_rel3", 32'(release_o), 32'h040);
    step(0, 0, 2'd0, 0, 0);
    check_eq("sweep_rel4", 32'(release_o), 32'h000);
    check_eq("sweep_busy4", 32'(busy_o), 32'd1);
    step(0, 0, 2'd0, 0, 0);
    check_eq("sweep_busy5", 32'(busy_o), 32'd0);
    check_eq("sweep_ready5", 32'(cmd_ready), 32'd1);

    // Command held across a rise waits one cycle
    step(0, 1, 2'd1, 5, 2);
    step(1, 1, 2'd1, 7, 3);
    check_eq("rise_blocks_cmd", 32'(obs_ready), 32'd0);
    step(1, 1, 2'd1, 7, 3);
    check_eq("cmd_after_rise", 32'(obs_ready), 32'd1);
    check_eq("force_5_7", 32'(force_o), 32'h0A0);

    // Rise during sweep defers the armed apply
    step(0, 0, 2'd0, 0, 0);
    repeat (4) step(0, 0, 2'd0, 0, 0);
    step(0, 1, 2'd1, 2, 1);
    step(0, 1, 2'd3, 0, 0);
    check_eq("rall_busy", 32'(busy_o), 32'd1);
    step(1, 0, 2'd0, 0, 0);
    check_eq("pend_not_yet", 32'(force_o), 32'h000);
    step(1, 0, 2'd0, 0, 0);
    check_eq("pend_applied", 32'(force_o), 32'h004);

    // Out-of-range index
    step(1, 1, 2'd1, 12, 1);
    check_eq("oor_err", 32'(err_o), 32'd1);
    check_eq("oor_force", 32'(force_o), 32'h004);
    step(1, 1, 2'd1, 9, 3);
    check_eq("idx9_err", 32'(err_o), 32'd0);
    check_eq("idx9_force", 32'(force_o), 32'h204);

    // Asynchronous reset mid-sweep
    step(1, 1, 2'd1, 0, 1);
    step(0, 0, 2'd0, 0, 0);
    check_eq("pre_rst_rel", 32'(release_o), 32'h001);
    async_reset();
    check_eq("midsweep_force", 32'(force_o), 32'h0);
    check_eq("midsweep_busy", 32'(busy_o), 32'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic e;
      e = en;
      if ($urandom_range(0, 9) == 0) e = ~e;
      step(e, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      if (n == 750) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
